// File: rtl/vrf_wb_arbiter.sv
// Write-back arbiter: buffers ALU and MFPU result writes in per-source FIFOs and
// merges them round-robin onto the single VRF write port. Optional macro VRF_WB_STATS_EN adds counters.
module vrf_wb_arbiter #(
    parameter int DataWidth = 64,
    parameter int AddrWidth = 10,
    parameter int IdWidth   = 3,
    parameter int Depth     = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   alu_result_req_i,
    input  logic [IdWidth-1:0]     alu_result_id_i,
    input  logic [AddrWidth-1:0]   alu_result_addr_i,
    input  logic [DataWidth-1:0]   alu_result_wdata_i,
    input  logic [DataWidth/8-1:0] alu_result_be_i,
    output logic                   alu_result_gnt_o,
    input  logic                   mfpu_result_req_i,
    input  logic [IdWidth-1:0]     mfpu_result_id_i,
    input  logic [AddrWidth-1:0]   mfpu_result_addr_i,
    input  logic [DataWidth-1:0]   mfpu_result_wdata_i,
    input  logic [DataWidth/8-1:0] mfpu_result_be_i,
    output logic                   mfpu_result_gnt_o,
`ifdef VRF_WB_STATS_EN
    output logic [31:0]            alu_wb_cnt_o,
    output logic [31:0]            mfpu_wb_cnt_o,
    output logic [31:0]            stall_cnt_o,
`endif
    output logic                   wb_valid_o,
    input  logic                   wb_ready_i,
    output logic                   wb_src_o,
    output logic [IdWidth-1:0]     wb_id_o,
    output logic [AddrWidth-1:0]   wb_addr_o,
    output logic [DataWidth-1:0]   wb_wdata_o,
    output logic [DataWidth/8-1:0] wb_be_o
);

    localparam int BeWidth = DataWidth / 8;
    localparam int PtrW    = $clog2(Depth);
    localparam int CntW    = PtrW + 1;
    localparam int EntryW  = IdWidth + AddrWidth + DataWidth + BeWidth;

    logic [EntryW-1:0] mem_r    [2][Depth];
    logic [PtrW-1:0]   wr_ptr_r [2];
    logic [PtrW-1:0]   rd_ptr_r [2];
    logic [CntW-1:0]   cnt_r    [2];
    logic [EntryW-1:0] wentry_s [2];
    logic [EntryW-1:0] head_s;
    logic [1:0]        req_s;
    logic [1:0]        gnt_s;
    logic [1:0]        full_s;
    logic [1:0]        nonempty_s;
    logic [1:0]        pop_s;
    logic              rr_r;
    logic              hold_r;
    logic              hold_src_r;
    logic              sel_s;
    logic              valid_s;
    logic              hs_s;

    assign req_s       = {mfpu_result_req_i, alu_result_req_i};
    assign wentry_s[0] = {alu_result_id_i, alu_result_addr_i, alu_result_wdata_i, alu_result_be_i};
    assign wentry_s[1] = {mfpu_result_id_i, mfpu_result_addr_i, mfpu_result_wdata_i, mfpu_result_be_i};

    // FIFO status and accept grants; grants look only at the count, never at wb_ready_i
    always_comb begin
        full_s     = 2'b00;
        nonempty_s = 2'b00;
        gnt_s      = 2'b00;
        for (int s = 0; s < 2; s++) begin
            full_s[s]     = (cnt_r[s] == CntW'(Depth));
            nonempty_s[s] = (cnt_r[s] != {CntW{1'b0}});
            gnt_s[s]      = req_s[s] & ~full_s[s];
        end
    end

    // Source selection from registered state only; a stalled entry stays selected until taken
    always_comb begin
        valid_s = |nonempty_s;
        if (hold_r) begin
            sel_s = hold_src_r;
        end else if (&nonempty_s) begin
            sel_s = rr_r;
        end else if (nonempty_s[1]) begin
            sel_s = 1'b1;
        end else begin
            sel_s = 1'b0;
        end
        hs_s  = valid_s & wb_ready_i;
        pop_s = 2'b00;
        if (hs_s) begin
            pop_s[sel_s] = 1'b1;
        end else begin
            pop_s = 2'b00;
        end
        head_s = mem_r[sel_s][rd_ptr_r[sel_s]];
    end

    assign alu_result_gnt_o  = gnt_s[0];
    assign mfpu_result_gnt_o = gnt_s[1];
    assign wb_valid_o        = valid_s;
    assign wb_src_o          = sel_s;
    assign {wb_id_o, wb_addr_o, wb_wdata_o, wb_be_o} = head_s;

    // Entry storage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < 2; s++) begin
                for (int d = 0; d < Depth; d++) begin
                    mem_r[s][d] <= {EntryW{1'b0}};
                end
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (gnt_s[s]) begin
                    mem_r[s][wr_ptr_r[s]] <= wentry_s[s];
                end
            end
        end
    end

    // Read/write pointers and occupancy counts
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < 2; s++) begin
                wr_ptr_r[s] <= {PtrW{1'b0}};
                rd_ptr_r[s] <= {PtrW{1'b0}};
                cnt_r[s]    <= {CntW{1'b0}};
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (gnt_s[s]) begin
                    wr_ptr_r[s] <= wr_ptr_r[s] + {{(PtrW-1){1'b0}}, 1'b1};
                end
                if (pop_s[s]) begin
                    rd_ptr_r[s] <= rd_ptr_r[s] + {{(PtrW-1){1'b0}}, 1'b1};
                end
                cnt_r[s] <= cnt_r[s] + {{PtrW{1'b0}}, gnt_s[s]} - {{PtrW{1'b0}}, pop_s[s]};
            end
        end
    end

    // Round-robin pointer and stall hold state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_r       <= 1'b0;
            hold_r     <= 1'b0;
            hold_src_r <= 1'b0;
        end else begin
            if (hs_s && (&nonempty_s)) begin
                rr_r <= ~sel_s;
            end
            hold_r     <= valid_s & ~wb_ready_i;
            hold_src_r <= sel_s;
        end
    end

`ifdef VRF_WB_STATS_EN
    logic [31:0] alu_wb_cnt_r;
    logic [31:0] mfpu_wb_cnt_r;
    logic [31:0] stall_cnt_r;

    // Handshake and stall statistics, wrapping at 2^32
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            alu_wb_cnt_r  <= 32'd0;
            mfpu_wb_cnt_r <= 32'd0;
            stall_cnt_r   <= 32'd0;
        end else begin
            if (pop_s[0]) begin
                alu_wb_cnt_r <= alu_wb_cnt_r + 32'd1;
            end
            if (pop_s[1]) begin
                mfpu_wb_cnt_r <= mfpu_wb_cnt_r + 32'd1;
            end
            if (valid_s && !wb_ready_i) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
        end
    end

    assign alu_wb_cnt_o  = alu_wb_cnt_r;
    assign mfpu_wb_cnt_o = mfpu_wb_cnt_r;
    assign stall_cnt_o   = stall_cnt_r;
`endif

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Directed self-checking bench for vrf_wb_arbiter; covers VRF_WB_STATS_EN when defined.
module tb_vrf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_req, mfpu_req, alu_gnt, mfpu_gnt;
    logic [2:0]  alu_id, mfpu_id, wb_id;
    logic [9:0]  alu_addr, mfpu_addr, wb_addr;
    logic [63:0] alu_wdata, mfpu_wdata, wb_wdata;
    logic [7:0]  alu_be, mfpu_be, wb_be;
    logic        wb_valid, wb_ready, wb_src;
`ifdef VRF_WB_STATS_EN
    logic [31:0] alu_wb_cnt, mfpu_wb_cnt, stall_cnt;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vrf_wb_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .alu_result_req_i(alu_req), .alu_result_id_i(alu_id), .alu_result_addr_i(alu_addr),
        .alu_result_wdata_i(alu_wdata), .alu_result_be_i(alu_be), .alu_result_gnt_o(alu_gnt),
        .mfpu_result_req_i(mfpu_req), .mfpu_result_id_i(mfpu_id), .mfpu_result_addr_i(mfpu_addr),
        .mfpu_result_wdata_i(mfpu_wdata), .mfpu_result_be_i(mfpu_be), .mfpu_result_gnt_o(mfpu_gnt),
`ifdef VRF_WB_STATS_EN
        .alu_wb_cnt_o(alu_wb_cnt), .mfpu_wb_cnt_o(mfpu_wb_cnt), .stall_cnt_o(stall_cnt),
`endif
        .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_src_o(wb_src), .wb_id_o(wb_id),
        .wb_addr_o(wb_addr), .wb_wdata_o(wb_wdata), .wb_be_o(wb_be)
    );

    task automatic test_reset();
        checks++;
        if ({wb_valid, wb_src, wb_id, wb_addr, wb_wdata, wb_be, alu_gnt, mfpu_gnt} !== 91'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {wb_valid, wb_src, wb_id, wb_addr, wb_wdata, wb_be, alu_gnt, mfpu_gnt});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_stall();
        @(negedge clk);
        mfpu_req = 1'b1; mfpu_addr = 10'h2A0; wb_ready = 1'b0;
        #1;
        checks++;
        if (mfpu_gnt !== 1'b1 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL stall_push: got gnt=%b valid=%b expected gnt=1 valid=0", mfpu_gnt, wb_valid);
        end
        @(negedge clk);
        mfpu_req = 1'b0; alu_req = 1'b1; alu_addr = 10'h0A0;
        #1;
        checks++;
        if (alu_gnt !== 1'b1 || wb_valid !== 1'b1 || wb_src !== 1'b1 || wb_addr !== 10'h2A0) begin
            errors++; $display("FAIL stall_c1: got gnt=%b valid=%b src=%b addr=%h expected 1 1 1 2a0", alu_gnt, wb_valid, wb_src, wb_addr);
        end
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            alu_req = 1'b0;
            wb_ready = (c == 4);
            #1;
            checks++;
            if (wb_valid !== 1'b1 || wb_src !== 1'b1 || wb_addr !== 10'h2A0) begin
                errors++; $display("FAIL stall_hold c%0d: got valid=%b src=%b addr=%h expected 1 1 2a0", c, wb_valid, wb_src, wb_addr);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (wb_valid !== 1'b1 || wb_src !== 1'b0 || wb_addr !== 10'h0A0) begin
            errors++; $display("FAIL stall_alu_after: got valid=%b src=%b addr=%h expected 1 0 0a0", wb_valid, wb_src, wb_addr);
        end
        @(negedge clk); #1;
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++; $display("FAIL stall_empty: got valid=%b expected 0", wb_valid);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        alu_req = 1'b1; alu_id = 3'd5; alu_addr = 10'h012;
        alu_wdata = 64'h0000_0000_DEAD_BEEF; alu_be = 8'hFF; wb_ready = 1'b1;
        #1;
        checks++;
        if (alu_gnt !== 1'b1 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL single_accept: got gnt=%b valid=%b expected gnt=1 valid=0", alu_gnt, wb_valid);
        end
        @(negedge clk);
        alu_req = 1'b0;
        #1;
        checks++;
        if ({wb_valid, wb_src, wb_id, wb_addr, wb_wdata, wb_be} !== {1'b1, 1'b0, 3'd5, 10'h012, 64'h0000_0000_DEAD_BEEF, 8'hFF}) begin
            errors++; $display("FAIL single_fields: got %h expected %h", {wb_valid, wb_src, wb_id, wb_addr, wb_wdata, wb_be},
                               {1'b1, 1'b0, 3'd5, 10'h012, 64'h0000_0000_DEAD_BEEF, 8'hFF});
        end
        @(negedge clk); #1;
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++; $display("FAIL single_empty: got valid=%b expected 0", wb_valid);
        end
    endtask

    task automatic test_contention();
        logic       exp_src;
        logic [9:0] exp_addr;
        @(negedge clk);
        alu_req = 1'b1; alu_addr = 10'h100; mfpu_req = 1'b1; mfpu_addr = 10'h200; wb_ready = 1'b1;
        #1;
        checks++;
        if (alu_gnt !== 1'b1 || mfpu_gnt !== 1'b1) begin
            errors++; $display("FAIL cont_gnt0: got alu=%b mfpu=%b expected 1 1", alu_gnt, mfpu_gnt);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                alu_addr = 10'h101; mfpu_addr = 10'h201;
            end else begin
                alu_req = 1'b0; mfpu_req = 1'b0;
            end
            #1;
            exp_src  = (k % 2 == 1);
            exp_addr = (exp_src ? 10'h200 : 10'h100) + 10'(k / 2);
            checks++;
            if (wb_valid !== 1'b1 || wb_src !== exp_src || wb_addr !== exp_addr) begin
                errors++; $display("FAIL cont_order k%0d: got valid=%b src=%b addr=%h expected 1 %b %h", k, wb_valid, wb_src, wb_addr, exp_src, exp_addr);
            end
        end
        @(negedge clk); #1;
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++; $display("FAIL cont_empty: got valid=%b expected 0", wb_valid);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] req_v, rdy_v, gnt_v, val_v;
        logic [9:0] exp_addr;
        req_v = 8'b0011_1111; rdy_v = 8'b1111_0000; gnt_v = 8'b0010_0011; val_v = 8'b0111_1110;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            alu_req = req_v[k]; alu_addr = 10'h300 + 10'(k); wb_ready = rdy_v[k];
            #1;
            case (k)
                5:       exp_addr = 10'h301;
                6:       exp_addr = 10'h305;
                default: exp_addr = 10'h300;
            endcase
            checks++;
            if (alu_gnt !== gnt_v[k] || wb_valid !== val_v[k] || (val_v[k] && (wb_addr !== exp_addr || wb_src !== 1'b0))) begin
                errors++; $display("FAIL bp c%0d: got gnt=%b valid=%b src=%b addr=%h expected gnt=%b valid=%b src=0 addr=%h",
                                   k, alu_gnt, wb_valid, wb_src, wb_addr, gnt_v[k], val_v[k], exp_addr);
            end
        end
    endtask

    task automatic test_reset_midflight();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            wb_ready = 1'b0; alu_req = 1'b1; mfpu_req = 1'b1;
            alu_addr = 10'h3C0 + 10'(k); mfpu_addr = 10'h3E0 + 10'(k);
        end
        @(negedge clk); #1;
        checks++;
        if (alu_gnt !== 1'b0 || wb_valid !== 1'b1) begin
            errors++; $display("FAIL mid_full: got gnt=%b valid=%b expected 0 1", alu_gnt, wb_valid);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || alu_gnt !== 1'b1) begin
            errors++; $display("FAIL mid_async: got valid=%b gnt=%b expected 0 1", wb_valid, alu_gnt);
        end
        alu_req = 1'b0; mfpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        alu_req = 1'b1; mfpu_req = 1'b1; alu_addr = 10'h111; mfpu_addr = 10'h222; wb_ready = 1'b1;
        @(negedge clk);
        alu_req = 1'b0; mfpu_req = 1'b0;
        #1;
        checks++;
        if (wb_valid !== 1'b1 || wb_src !== 1'b0 || wb_addr !== 10'h111) begin
            errors++; $display("FAIL mid_rr_alu: got valid=%b src=%b addr=%h expected 1 0 111", wb_valid, wb_src, wb_addr);
        end
        @(negedge clk); #1;
        checks++;
        if (wb_valid !== 1'b1 || wb_src !== 1'b1 || wb_addr !== 10'h222) begin
            errors++; $display("FAIL mid_second: got valid=%b src=%b addr=%h expected 1 1 222", wb_valid, wb_src, wb_addr);
        end
        @(negedge clk);
    endtask

`ifdef VRF_WB_STATS_EN
    task automatic test_stats();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            alu_req = (k < 2); mfpu_req = (k < 2);
            alu_addr = 10'h100 + 10'(k); mfpu_addr = 10'h200 + 10'(k);
            wb_ready = (k >= 4);
        end
        @(negedge clk); #1;
        checks++;
        if (alu_wb_cnt !== 32'd2 || mfpu_wb_cnt !== 32'd2 || stall_cnt !== 32'd3) begin
            errors++; $display("FAIL stats: got alu=%0d mfpu=%0d stall=%0d expected 2 2 3", alu_wb_cnt, mfpu_wb_cnt, stall_cnt);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; wb_ready = 1'b0;
        alu_req = 1'b0; alu_id = 3'd0; alu_addr = 10'd0; alu_wdata = 64'd0; alu_be = 8'd0;
        mfpu_req = 1'b0; mfpu_id = 3'd0; mfpu_addr = 10'd0; mfpu_wdata = 64'd0; mfpu_be = 8'd0;
        #1;
        test_reset();
        test_stall();
        test_single();
        test_contention();
        test_backpressure();
        test_reset_midflight();
`ifdef VRF_WB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
